pam4_mapper: RTL and testbench

Transmit-side 4-PAM symbol mapper for the DSP modem. It accepts bytes over a valid/ready handshake and splits each byte into four dibits, MSB pair first. Each dibit becomes an 18-bit signed constellation level (±b, ±3b), emitted once per symbol period as a zero-stuffed impulse train at SPS samples per symbol. The output feeds the transmit pulse-shaping filter. Its level mapping is the exact inverse of the receive slicer's decision rule: 11→+3b, 10→+b, 01→−b, 00→−3b.

---
 rtl/pam4_mapper_pkg.sv | 44 ++++
 rtl/pam4_mapper_if.sv | 26 ++
 rtl/pam4_level_lut.sv | 17 +
 rtl/pam4_mapper.sv | 87 ++++++++
 tb/tb_pam4_mapper.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pam4_mapper_pkg.sv
// Shared modem definitions: level width, PAM4 dibit codes, level mapping.
// Purely combinational helpers; no latency.
// No flow control; consumed by the mapper and the receive-side slicer.
package modem_pkg;

    localparam int W = 18;

    // Dibit codes as seen on the wire; the slicer decodes into the same set.
    typedef enum logic [1:0] {
        PAM4_M3 = 2'b00,
        PAM4_M1 = 2'b01,
        PAM4_P1 = 2'b10,
        PAM4_P3 = 2'b11
    } pam4_sym_e;

    localparam int LVL_MAX_I = (2 ** (W - 1)) - 1;
    localparam int LVL_MIN_I = -(2 ** (W - 1));

    // Dibit and amplitude b to a saturated signed level (+-b, +-3b).
    // Arithmetic is done two bits wider so 3b cannot wrap before clamping.
    function automatic logic signed [W-1:0] pam4_level(
        input logic [1:0]          dibit,
        input logic signed [W-1:0] b
    );
        logic signed [W+1:0] b_x;
        logic signed [W+1:0] b3;
        logic signed [W+1:0] v;
        b_x = {{2{b[W-1]}}, b};
        b3  = (b_x <<< 1) + b_x;
        case (dibit)
            PAM4_P3: v = b3;
            PAM4_P1: v = b_x;
            PAM4_M1: v = -b_x;
            default: v = -b3;
        endcase
        if (v > (W+2)'(LVL_MAX_I)) begin
            v = (W+2)'(LVL_MAX_I);
        end else if (v < (W+2)'(LVL_MIN_I)) begin
            v = (W+2)'(LVL_MIN_I);
        end
        return v[W-1:0];
    endfunction

endpackage

// File: rtl/pam4_mapper_if.sv
// Byte input handshake plus symbol sample output of the PAM4 mapper.
// Wires only; no latency.
// data_valid/data_ready handshake on the byte side; output has no backpressure.
interface pam4_mapper_if;
    import modem_pkg::*;

    logic [7:0]          data_in;
    logic                data_valid;
    logic                data_ready;
    logic signed [W-1:0] mapper_out;
    logic                sym_strobe;
    logic                underrun;

    // Byte source / sample sink side
    modport master (
        output data_in, data_valid,
        input  data_ready, mapper_out, sym_strobe, underrun
    );

    // Mapper side
    modport slave (
        input  data_in, data_valid,
        output data_ready, mapper_out, sym_strobe, underrun
    );

endinterface

// File: rtl/pam4_level_lut.sv
// Combinational dibit + amplitude b to saturated PAM4 level.
// Zero latency.
// No flow control.
module pam4_level_lut
    import modem_pkg::*;
(
    input  logic [1:0]          i_dibit,
    input  logic signed [W-1:0] i_b,
    output logic signed [W-1:0] o_level
);

    // Single source of truth for the mapping lives in the package.
    always_comb begin
        o_level = pam4_level(i_dibit, i_b);
    end

endmodule

// File: rtl/pam4_mapper.sv
// Byte to 4-PAM impulse-train mapper, four dibits per byte MSB pair first.
// Symbol consumed in cycle t appears on mapper_out/sym_strobe in cycle t+1.
// data_ready only when the buffer is empty or its last dibit is consumed now.
module pam4_mapper
    import modem_pkg::*;
#(
    parameter int SPS = 4
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_tx_en,
    input  logic signed [W-1:0] i_b_level,
    pam4_mapper_if.slave        bus
);

    localparam int CW = $clog2(SPS);

    logic [CW-1:0]       r_cnt;
    logic [7:0]          r_shift;
    logic [2:0]          r_rem;
    logic signed [W-1:0] r_out;
    logic                r_stb;
    logic                r_und;

    logic                w_slot;
    logic                w_ready;
    logic                w_load;
    logic signed [W-1:0] w_level;

    assign w_slot  = i_tx_en && (r_cnt == '0);
    // Ready on the last dibit's slot lets a new byte land with no symbol gap.
    assign w_ready = (r_rem == 3'd0) || ((r_rem == 3'd1) && w_slot);
    assign w_load  = bus.data_valid && w_ready;

    assign bus.data_ready = w_ready;
    assign bus.mapper_out = r_out;
    assign bus.sym_strobe = r_stb;
    assign bus.underrun   = r_und;

    // b is looked up live, so a new amplitude takes effect at the next slot.
    pam4_level_lut u_lut (
        .i_dibit (r_shift[7:6]),
        .i_b     (i_b_level),
        .o_level (w_level)
    );

    // Sample phase counter; parked at 0 while disabled so enable starts on a slot.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n || !i_tx_en) begin
            r_cnt <= '0;
        end else if (r_cnt == CW'(SPS - 1)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Dibit buffer and registered outputs; a load overrides the consume update.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_shift <= '0;
            r_rem   <= '0;
            r_out   <= '0;
            r_stb   <= 1'b0;
            r_und   <= 1'b0;
        end else begin
            r_out <= '0;
            r_stb <= 1'b0;
            r_und <= 1'b0;
            if (w_slot) begin
                if (r_rem != 3'd0) begin
                    r_out   <= w_level;
                    r_stb   <= 1'b1;
                    r_shift <= {r_shift[5:0], 2'b00};
                    r_rem   <= r_rem - 3'd1;
                end else begin
                    r_und <= 1'b1;
                end
            end
            if (w_load) begin
                r_shift <= bus.data_in;
                r_rem   <= 3'd4;
            end
        end
    end

endmodule

// File: tb/tb_pam4_mapper.sv
// Self-checking bench for pam4_mapper: directed scenarios plus random loopback.
// Reference model keeps a dibit queue and a sample phase, checked every cycle.
// Outputs sampled 1 time unit after the rising edge; inputs driven there too.
module tb_pam4_mapper;
    import modem_pkg::*;

    localparam int SPS = 4;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                tx_en;
    logic signed [W-1:0] b_level;

    pam4_mapper_if u_bus ();

    pam4_mapper #(.SPS(SPS)) dut (
        .i_clk     (clk),
        .i_reset_n (reset_n),
        .i_tx_en   (tx_en),
        .i_b_level (b_level),
        .bus       (u_bus)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    int q[$];
    int ph = 0;
    int und_cnt = 0;
    int sym_log[$];
    int rx_dibits[$];
    int tx_bytes[$];

    function automatic int ref_level(int d, int b);
        int v;
        v = (2 * d - 3) * b;
        if (v > LVL_MAX_I) v = LVL_MAX_I;
        if (v < LVL_MIN_I) v = LVL_MIN_I;
        return v;
    endfunction

    function automatic int slice(int y, int b);
        if (y >= 2 * b) return 3;
        if (y >= 0) return 2;
        if (y >= -2 * b) return 1;
        return 0;
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        n_assert++;
        n_fail++;
        $error("FAIL %s: wait bound expired", tag);
    endtask

    // One clock cycle with full model check of data_ready and the outputs.
    task automatic cycle();
        bit slot;
        bit rdy;
        int exp_out;
        int exp_stb;
        int exp_und;
        int d;
        slot = tx_en && (ph == 0);
        rdy  = (q.size() == 0) || (q.size() == 1 && slot);
        chk("data_ready", u_bus.data_ready, rdy);
        exp_out = 0;
        exp_stb = 0;
        exp_und = 0;
        if (!reset_n) begin
            q.delete();
            ph = 0;
        end else begin
            if (slot) begin
                if (q.size() > 0) begin
                    d = q.pop_front();
                    exp_out = ref_level(d, int'(b_level));
                    exp_stb = 1;
                end else begin
                    exp_und = 1;
                end
            end
            if (u_bus.data_valid && rdy) begin
                for (int k = 3; k >= 0; k--) q.push_back((int'(u_bus.data_in) >> (2 * k)) & 3);
                tx_bytes.push_back(int'(u_bus.data_in));
            end
            ph = tx_en ? (ph + 1) % SPS : 0;
        end
        @(posedge clk);
        #1;
        chk("mapper_out", $signed(u_bus.mapper_out), exp_out);
        chk("sym_strobe", u_bus.sym_strobe, exp_stb);
        chk("underrun", u_bus.underrun, exp_und);
        if (u_bus.underrun === 1'b1) und_cnt++;
        if (u_bus.sym_strobe === 1'b1) begin
            sym_log.push_back(int'($signed(u_bus.mapper_out)));
            rx_dibits.push_back(slice(int'($signed(u_bus.mapper_out)), int'(b_level)));
        end
    endtask

    // Present a byte until accepted; data_valid is left high for streaming.
    task automatic send_byte(input logic [7:0] v, input int max_wait);
        bit acc;
        acc = 0;
        u_bus.data_in    = v;
        u_bus.data_valid = 1'b1;
        for (int i = 0; i < max_wait && !acc; i++) begin
            acc = (u_bus.data_ready === 1'b1);
            cycle();
        end
        if (!acc) timeout("send_byte");
    endtask

    task automatic idle(input int n);
        u_bus.data_valid = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_syms(input int n, input int max_wait);
        int i;
        i = 0;
        while (sym_log.size() < n && i < max_wait) begin
            cycle();
            i++;
        end
        if (sym_log.size() < n) timeout("wait_syms");
    endtask

    initial begin
        int rb;
        int nbytes;
        int byte_val;
        logic [7:0] rnd;

        reset_n          = 1'b0;
        tx_en            = 1'b0;
        b_level          = 18'sd1000;
        u_bus.data_in    = 8'h00;
        u_bus.data_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", u_bus.data_ready, 1);
        chk("reset_out", $signed(u_bus.mapper_out), 0);
        chk("reset_strobe", u_bus.sym_strobe, 0);
        chk("reset_underrun", u_bus.underrun, 0);
        cycle();
        reset_n = 1'b1;
        tx_en   = 1'b1;

        // Single byte 0xE4 at b=1000, then idle underruns
        sym_log.delete();
        send_byte(8'hE4, 8);
        idle(24);
        chk("e4_count", sym_log.size(), 4);
        if (sym_log.size() == 4) begin
            chk("e4_s0", sym_log[0], 3000);
            chk("e4_s1", sym_log[1], 1000);
            chk("e4_s2", sym_log[2], -1000);
            chk("e4_s3", sym_log[3], -3000);
        end

        // Continuous stream 0xFF,0x00,0xFF,0x00 with no gaps or underrun
        sym_log.delete();
        send_byte(8'hFF, 8);
        und_cnt = 0;
        send_byte(8'h00, 40);
        send_byte(8'hFF, 40);
        send_byte(8'h00, 40);
        chk("stream_underrun", und_cnt, 0);
        idle(20);
        chk("stream_count", sym_log.size(), 16);
        if (sym_log.size() == 16) begin
            chk("stream_s3", sym_log[3], 3000);
            chk("stream_s4", sym_log[4], -3000);
            chk("stream_s8", sym_log[8], 3000);
        end

        // Saturation at b=50000
        b_level = 18'sd50000;
        sym_log.delete();
        send_byte(8'hE4, 8);
        idle(20);
        chk("sat_count", sym_log.size(), 4);
        if (sym_log.size() == 4) begin
            chk("sat_p3", sym_log[0], 131071);
            chk("sat_p1", sym_log[1], 50000);
            chk("sat_m1", sym_log[2], -50000);
            chk("sat_m3", sym_log[3], -131072);
        end

        // Reset after the second dibit discards the rest of the byte
        b_level = 18'sd1000;
        sym_log.delete();
        send_byte(8'hE4, 8);
        u_bus.data_valid = 1'b0;
        wait_syms(2, 40);
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
        idle(20);
        chk("midreset_count", sym_log.size(), 2);

        // tx_en low for 10 cycles mid-byte, then resume
        sym_log.delete();
        send_byte(8'hE4, 8);
        u_bus.data_valid = 1'b0;
        wait_syms(1, 40);
        tx_en = 1'b0;
        und_cnt = 0;
        idle(10);
        chk("disable_underrun", und_cnt, 0);
        chk("disable_count", sym_log.size(), 1);
        tx_en = 1'b1;
        idle(1);
        chk("resume_first", sym_log.size(), 2);
        idle(20);
        chk("resume_count", sym_log.size(), 4);

        // Random loopback through the slicer at threshold 2b
        rb = $urandom_range(1, 40000);
        b_level = W'(rb);
        idle(24);
        tx_bytes.delete();
        rx_dibits.delete();
        nbytes = 0;
        for (int i = 0; i < 40; i++) begin
            rnd = 8'($urandom_range(0, 255));
            send_byte(rnd, 200);
            u_bus.data_valid = 1'b0;
            repeat ($urandom_range(0, 6)) begin
                tx_en = ($urandom_range(0, 7) != 0);
                cycle();
            end
            tx_en = 1'b1;
        end
        idle(40);
        nbytes = tx_bytes.size();
        chk("loop_nbytes", nbytes, 40);
        chk("loop_ndibits", rx_dibits.size(), 4 * nbytes);
        if (rx_dibits.size() == 4 * nbytes) begin
            for (int i = 0; i < nbytes; i++) begin
                byte_val = (rx_dibits[4*i] << 6) | (rx_dibits[4*i+1] << 4) |
                           (rx_dibits[4*i+2] << 2) | rx_dibits[4*i+3];
                chk("loop_byte", byte_val, tx_bytes[i]);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
